// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK, idle wait.
// Optional PS2_RESP_CHECK_EN adds reception and checking of the device's response byte.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 500,
  parameter int unsigned TIMEOUT_CYCLES = 75000
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iStart,
  input  logic [7:0] iData,
  inout  wire        ps2clk,
  inout  wire        ps2data,
  output logic       oBusy,
  output logic       oDone,
  output logic [1:0] oErrCode,
  output logic [7:0] oResp
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
`ifdef PS2_RESP_CHECK_EN
  localparam logic [1:0] ERR_RESP = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE,
`ifdef PS2_RESP_CHECK_EN
    S_RESP,
`endif
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          clk_s, data_s, fe, line_idle;
  logic [7:0]    tx_byte;
  logic          tx_bit;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic [1:0]    err_q;
  logic          counting, tmo;
  logic          clk_low, data_low;

  // Open-drain outputs: only ever pull low or float
  assign ps2clk  = clk_low  ? 1'b0 : 1'bz;
  assign ps2data = data_low ? 1'b0 : 1'bz;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2clk};
      data_sync <= {data_sync[0], ps2data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign clk_s     = clk_sync[1];
  assign data_s    = data_sync[1];
  assign fe        = clk_prev & ~clk_s;
  assign line_idle = clk_s & data_s;

  always_comb begin
    counting = 1'b0;
    case (state_q)
      S_SEND, S_ACK, S_WAIT_IDLE: counting = 1'b1;
`ifdef PS2_RESP_CHECK_EN
      S_RESP:                     counting = 1'b1;
`endif
      default:                    counting = 1'b0;
    endcase
  end

  // An idle line in WAIT_IDLE wins over a coincident timeout
  assign tmo = counting && !fe && (tcnt == TMO_LAST) &&
               !(state_q == S_WAIT_IDLE && line_idle);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (iStart) state_d = S_INHIBIT;
      S_INHIBIT:   if (icnt == INH_LAST) state_d = S_RTS;
      S_RTS:       state_d = S_SEND;
      S_SEND: begin
        if (tmo)                          state_d = S_DONE;
        else if (fe && bit_cnt == 4'd9)   state_d = S_ACK;
      end
      S_ACK: begin
        if (tmo)     state_d = S_DONE;
        else if (fe) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (line_idle) begin
`ifdef PS2_RESP_CHECK_EN
          state_d = (err_q == ERR_NACK) ? S_DONE : S_RESP;
`else
          state_d = S_DONE;
`endif
        end else if (tmo) begin
          state_d = S_DONE;
        end
      end
`ifdef PS2_RESP_CHECK_EN
      S_RESP: begin
        if (tmo)                         state_d = S_DONE;
        else if (fe && bit_cnt == 4'd10) state_d = S_DONE;
      end
`endif
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clk_low  = 1'b0;
    data_low = 1'b0;
    oBusy    = 1'b1;
    oDone    = 1'b0;
    case (state_q)
      S_IDLE:    oBusy = 1'b0;
      S_INHIBIT: clk_low = 1'b1;
      S_RTS: begin
        clk_low  = 1'b1;
        data_low = 1'b1;
      end
      S_SEND:    data_low = ~tx_bit;
      S_DONE: begin
        oBusy = 1'b0;
        oDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign oErrCode = err_q;

`ifdef PS2_RESP_CHECK_EN
  logic [7:0] rx_shift, resp_q;
  logic       rx_start, rx_par;
  assign oResp = resp_q;
`else
  assign oResp = 8'h00;
`endif

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      tx_byte <= '0;
      tx_bit  <= 1'b1;
      bit_cnt <= '0;
      icnt    <= '0;
      tcnt    <= '0;
      err_q   <= ERR_OK;
`ifdef PS2_RESP_CHECK_EN
      rx_shift <= '0;
      rx_start <= 1'b0;
      rx_par   <= 1'b0;
      resp_q   <= '0;
`endif
    end else begin
      if (state_q == S_IDLE && iStart) begin
        tx_byte <= iData;
        err_q   <= ERR_OK;
        icnt    <= '0;
      end
      if (state_q == S_INHIBIT) icnt <= icnt + 1'b1;
      // Start bit goes on the line as SEND is entered
      if (state_q == S_RTS) begin
        tcnt    <= '0;
        bit_cnt <= '0;
        tx_bit  <= 1'b0;
      end
      if (counting) begin
        if (fe)       tcnt  <= '0;
        else if (tmo) err_q <= ERR_TMO;
        else          tcnt  <= tcnt + 1'b1;
      end
      if (state_q == S_SEND && fe) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt < 4'd8)       tx_bit <= tx_byte[bit_cnt[2:0]];
        else if (bit_cnt == 4'd8) tx_bit <= ~^tx_byte;
        else                      tx_bit <= 1'b1;
      end
      if (state_q == S_ACK && fe && data_s) err_q <= ERR_NACK;
      if (state_q == S_WAIT_IDLE) bit_cnt <= '0;
`ifdef PS2_RESP_CHECK_EN
      if (state_q == S_RESP && fe) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == 4'd0)      rx_start <= data_s;
        else if (bit_cnt < 4'd9)  rx_shift <= {data_s, rx_shift[7:1]};
        else if (bit_cnt == 4'd9) rx_par   <= data_s;
        else begin
          resp_q <= rx_shift;
          // Odd parity over data+parity; stop must be high
          if (rx_start || !(^{rx_shift, rx_par}) || !data_s || rx_shift != 8'hFA)
            err_q <= ERR_RESP;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on open-drain lines, table-driven and random frames.
module tb_ps2_host_tx;

  localparam int INH = 500;
  localparam int TMO = 3000;

  logic       iClk = 1'b0;
  logic       iRstN = 1'b0;
  logic       iStart = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oBusy, oDone;
  logic [1:0] oErrCode;
  logic [7:0] oResp;
  wire        ps2clk, ps2data;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  pullup (ps2clk);
  pullup (ps2data);
  assign ps2clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iData(iData),
    .ps2clk(ps2clk), .ps2data(ps2data),
    .oBusy(oBusy), .oDone(oDone), .oErrCode(oErrCode), .oResp(oResp)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [1:0] last_err = 2'd0;

  always @(negedge iClk) begin
    if (oDone) begin
      done_cnt <= done_cnt + 1;
      last_err <= oErrCode;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference frame as seen by the device: start 0, D0..D7, odd parity, stop 1
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  function automatic int model_err(input bit ack, input logic [7:0] rb, input bit rbad);
    if (!ack) return 1;
`ifdef PS2_RESP_CHECK_EN
    if (rb != 8'hFA || rbad) return 3;
`endif
    return 0;
  endfunction

  task automatic start_cmd(input logic [7:0] d, output bit busy0);
    @(negedge iClk);
    iStart = 1'b1;
    iData  = d;
    @(negedge iClk);
    iStart = 1'b0;
    iData  = 8'($urandom);
    busy0  = oBusy;
  endtask

  // Counts inhibit cycles (clk low, data high) then RTS cycles (both low)
  task automatic wait_rts(output int inh, output int rts);
    int wd;
    wd = 0; inh = 0; rts = 0;
    while (!(ps2clk == 1'b0 && ps2data == 1'b0) && wd < 5000) begin
      if (ps2clk == 1'b0) inh++;
      @(negedge iClk);
      wd++;
    end
    while (ps2clk == 1'b0 && ps2data == 1'b0 && wd < 5000) begin
      rts++;
      @(negedge iClk);
      wd++;
    end
  endtask

  task automatic dev_pulse(input int hp, output bit s);
    dev_clk_low = 1'b1;
    repeat (hp) @(negedge iClk);
    dev_clk_low = 1'b0;
    repeat (hp / 2) @(negedge iClk);
    s = ps2data;
    repeat (hp / 2) @(negedge iClk);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input logic [7:0] rb,
                           input bit rbad, input bit poke, input int hp,
                           output logic [10:0] seen, output int inh, output int rts,
                           output int ndone, output logic [1:0] err, output logic [7:0] resp,
                           output bit busy0);
    int d0, wd;
    bit s;
    d0 = done_cnt;
    start_cmd(d, busy0);
    wait_rts(inh, rts);
    seen = '0;
    seen[0] = ps2data;
    repeat (hp / 2) @(negedge iClk);
    for (int i = 1; i <= 10; i++) begin
      if (poke && i == 3) begin
        @(negedge iClk);
        iStart = 1'b1;
        iData  = ~d;
        @(negedge iClk);
        iStart = 1'b0;
      end
      dev_pulse(hp, s);
      seen[i] = s;
    end
    dev_data_low = ack;
    repeat (hp / 2) @(negedge iClk);
    dev_pulse(hp, s);
    dev_data_low = 1'b0;
    repeat (hp / 2) @(negedge iClk);
`ifdef PS2_RESP_CHECK_EN
    if (ack) begin
      logic [10:0] rf;
      rf = model_frame(rb);
      rf[9] = rf[9] ^ rbad;
      for (int i = 0; i <= 10; i++) begin
        dev_data_low = ~rf[i];
        repeat (hp / 2) @(negedge iClk);
        dev_pulse(hp, s);
      end
      dev_data_low = 1'b0;
    end
`endif
    wd = 0;
    while (done_cnt == d0 && wd < 4000) begin
      @(negedge iClk);
      wd++;
    end
    repeat (5) @(negedge iClk);
    ndone = done_cnt - d0;
    err   = oErrCode;
    resp  = oResp;
  endtask

  typedef struct {
    logic [7:0] d;
    bit         ack;
    logic [7:0] rb;
    bit         rbad;
    bit         poke;
    int         hp;
    bit         exp_par;
    int         exp_err_plain;
    int         exp_err_resp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [10:0] seen;
    int inh, rts, ndone, n, d0;
    logic [1:0] err;
    logic [7:0] resp;
    bit busy0, s;
    int exp_err;

    vecs[0] = '{8'hF4, 1'b1, 8'hFA, 1'b0, 1'b0, 200, 1'b0, 0, 0};
    vecs[1] = '{8'hFF, 1'b1, 8'hFA, 1'b0, 1'b1, 40,  1'b1, 0, 0};
    vecs[2] = '{8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 40,  1'b1, 0, 3};
    vecs[3] = '{8'h01, 1'b1, 8'hFA, 1'b1, 1'b0, 40,  1'b0, 0, 3};
    vecs[4] = '{8'hF4, 1'b0, 8'hFA, 1'b0, 1'b0, 40,  1'b0, 1, 1};

    repeat (3) @(negedge iClk);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_err", oErrCode, 0);
    chk("rst_resp", oResp, 0);
    chk("rst_clk_z", ps2clk, 1);
    chk("rst_data_z", ps2data, 1);
    iRstN = 1'b1;
    repeat (3) @(negedge iClk);

    for (int v = 0; v < 5; v++) begin
`ifdef PS2_RESP_CHECK_EN
      exp_err = vecs[v].exp_err_resp;
`else
      exp_err = vecs[v].exp_err_plain;
`endif
      run_frame(vecs[v].d, vecs[v].ack, vecs[v].rb, vecs[v].rbad, vecs[v].poke, vecs[v].hp,
                seen, inh, rts, ndone, err, resp, busy0);
      chk($sformatf("v%0d_busy_start", v), busy0, 1);
      chk($sformatf("v%0d_inhibit", v), inh, INH);
      chk($sformatf("v%0d_rts", v), rts, 1);
      chk($sformatf("v%0d_frame", v), seen, model_frame(vecs[v].d));
      chk($sformatf("v%0d_parity", v), seen[9], vecs[v].exp_par);
      chk($sformatf("v%0d_ndone", v), ndone, 1);
      chk($sformatf("v%0d_err_at_done", v), last_err, exp_err);
      chk($sformatf("v%0d_err_held", v), err, exp_err);
      chk($sformatf("v%0d_busy_end", v), oBusy, 0);
`ifdef PS2_RESP_CHECK_EN
      if (vecs[v].ack) chk($sformatf("v%0d_resp", v), resp, vecs[v].rb);
`endif
    end

    for (int r = 0; r < 4; r++) begin
      logic [7:0] d, rb;
      bit ack, rbad;
      d    = 8'($urandom);
      ack  = ($urandom_range(0, 3) != 0);
      rb   = ($urandom_range(0, 1) != 0) ? 8'hFA : 8'($urandom);
      rbad = ($urandom_range(0, 3) == 0);
      run_frame(d, ack, rb, rbad, 1'b0, 40, seen, inh, rts, ndone, err, resp, busy0);
      chk($sformatf("r%0d_inhibit", r), inh, INH);
      chk($sformatf("r%0d_frame", r), seen, model_frame(d));
      chk($sformatf("r%0d_ndone", r), ndone, 1);
      chk($sformatf("r%0d_err", r), err, model_err(ack, rb, rbad));
`ifdef PS2_RESP_CHECK_EN
      if (ack) chk($sformatf("r%0d_resp", r), resp, rb);
`endif
    end

    // Device never clocks: timeout exactly TMO cycles after SEND entry
    start_cmd(8'hF4, busy0);
    wait_rts(inh, rts);
    n = 0;
    while (!oDone && n < TMO + 100) begin
      @(negedge iClk);
      n++;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_err", oErrCode, 2);
    chk("tmo_busy", oBusy, 0);
    chk("tmo_clk_z", ps2clk, 1);
    chk("tmo_data_z", ps2data, 1);
    repeat (5) @(negedge iClk);

    // Reset asserted at fe 5 aborts silently and releases the lines at once
    start_cmd(8'hF4, busy0);
    wait_rts(inh, rts);
    repeat (20) @(negedge iClk);
    for (int i = 1; i <= 4; i++) dev_pulse(40, s);
    dev_clk_low = 1'b1;
    chk("rst5_d3_driven", ps2data, 0);
    d0 = done_cnt;
    iRstN = 1'b0;
    #1;
    chk("rst5_data_z", ps2data, 1);
    chk("rst5_busy", oBusy, 0);
    dev_clk_low = 1'b0;
    #1;
    chk("rst5_clk_z", ps2clk, 1);
    repeat (5) @(negedge iClk);
    iRstN = 1'b1;
    repeat (100) @(negedge iClk);
    chk("rst5_no_done", done_cnt - d0, 0);
    chk("rst5_busy_after", oBusy, 0);

    run_frame(8'hF4, 1'b1, 8'hFA, 1'b0, 1'b0, 40, seen, inh, rts, ndone, err, resp, busy0);
    chk("fresh_frame", seen, model_frame(8'hF4));
    chk("fresh_ndone", ndone, 1);
    chk("fresh_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
